// File: rtl/compat_filter_40mhz.sv
// Upstream stage of the 40 MHz compatibility ToT trigger: 5-tap binomial FIR on three
// 120 MHz PMT streams, decimated by three, with a resynchronisable ENABLE40 phase.
module compat_filter_40mhz #(
    parameter int ADC_WIDTH = 12
) (
    input  logic                 CLK120,
    input  logic                 RESET,
    input  logic [ADC_WIDTH-1:0] ADC0,
    input  logic [ADC_WIDTH-1:0] ADC1,
    input  logic [ADC_WIDTH-1:0] ADC2,
    input  logic                 PHASE_SYNC,
    input  logic                 BYPASS,
    output logic [1:0]           ENABLE40,
    output logic [ADC_WIDTH-1:0] FILT0,
    output logic [ADC_WIDTH-1:0] FILT1,
    output logic [ADC_WIDTH-1:0] FILT2
);

    localparam int SUM_WIDTH = ADC_WIDTH + 4;

    logic [ADC_WIDTH-1:0] adc_in [3];
    logic [ADC_WIDTH-1:0] taps   [3][5];
    logic [SUM_WIDTH-1:0] sum    [3];
    logic [ADC_WIDTH-1:0] y_next [3];
    logic [ADC_WIDTH-1:0] y      [3];
    logic [ADC_WIDTH-1:0] filt   [3];
    logic [1:0]           phase;
    logic                 load;

    assign adc_in[0] = ADC0;
    assign adc_in[1] = ADC1;
    assign adc_in[2] = ADC2;

    // Sync and the natural wrap both return the phase to 0; a coincident sync is the same single load.
    assign load = PHASE_SYNC || (phase == 2'd2);

    // Weights 1,4,6,4,1 sum to 16, so the rounded result always fits ADC_WIDTH bits.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum[c] = SUM_WIDTH'(taps[c][0])
                   + (SUM_WIDTH'(taps[c][1]) << 2)
                   + (SUM_WIDTH'(taps[c][2]) << 2)
                   + (SUM_WIDTH'(taps[c][2]) << 1)
                   + (SUM_WIDTH'(taps[c][3]) << 2)
                   + SUM_WIDTH'(taps[c][4]);
            y_next[c] = BYPASS ? taps[c][2]
                               : ADC_WIDTH'((sum[c] + SUM_WIDTH'(8)) >> 4);
        end
    end

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            phase <= 2'd0;
            for (int c = 0; c < 3; c++) begin
                y[c]    <= '0;
                filt[c] <= '0;
                for (int k = 0; k < 5; k++) begin
                    taps[c][k] <= '0;
                end
            end
        end else begin
            phase <= load ? 2'd0 : phase + 2'd1;
            for (int c = 0; c < 3; c++) begin
                taps[c][0] <= adc_in[c];
                for (int k = 1; k < 5; k++) begin
                    taps[c][k] <= taps[c][k-1];
                end
                y[c] <= y_next[c];
                if (load) begin
                    filt[c] <= y[c];
                end
            end
        end
    end

    assign ENABLE40 = phase;
    assign FILT0    = filt[0];
    assign FILT1    = filt[1];
    assign FILT2    = filt[2];

endmodule

// File: tb/tb_compat_filter_40mhz.sv
// Self-checking bench for compat_filter_40mhz: a behavioural convolution model feeds a
// scoreboard queue every cycle, plus table-driven and hand-written corner-case checks.
module tb_compat_filter_40mhz;

    logic        CLK120;
    logic        RESET;
    logic [11:0] ADC0, ADC1, ADC2;
    logic        PHASE_SYNC;
    logic        BYPASS;
    logic [1:0]  ENABLE40;
    logic [11:0] FILT0, FILT1, FILT2;

    int checks;
    int errors;

    typedef struct {
        int en;
        int f0;
        int f1;
        int f2;
    } exp_t;

    typedef struct {
        int   adc1;
        logic sync;
        int   exp_f1;
    } vec_t;

    exp_t sb_queue[$];

    // Model state: input history (index 0 newest), filtered value, phase and held output.
    int m_hist [3][5];
    int m_y    [3];
    int m_filt [3];
    int m_phase;
    int coef   [5];

    compat_filter_40mhz #(.ADC_WIDTH(12)) dut (
        .CLK120     (CLK120),
        .RESET      (RESET),
        .ADC0       (ADC0),
        .ADC1       (ADC1),
        .ADC2       (ADC2),
        .PHASE_SYNC (PHASE_SYNC),
        .BYPASS     (BYPASS),
        .ENABLE40   (ENABLE40),
        .FILT0      (FILT0),
        .FILT1      (FILT1),
        .FILT2      (FILT2)
    );

    initial begin
        CLK120 = 1'b0;
        forever #5 CLK120 = ~CLK120;
    end

    task automatic check_value(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_queue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected one entry");
        end else begin
            e = sb_queue.pop_front();
            check_value("sb_enable40", int'(ENABLE40), e.en);
            check_value("sb_filt0", int'(FILT0), e.f0);
            check_value("sb_filt1", int'(FILT1), e.f1);
            check_value("sb_filt2", int'(FILT2), e.f2);
        end
    endtask

    // Drives one cycle of inputs, advances the model, clocks the DUT and scores the result.
    task automatic applyStimulus(input int a0, input int a1, input int a2,
                                 input logic sync, input logic byp, input logic rst);
        int   in_val [3];
        int   acc;
        int   new_y;
        bit   do_load;
        exp_t e;
        ADC0       = 12'(a0);
        ADC1       = 12'(a1);
        ADC2       = 12'(a2);
        PHASE_SYNC = sync;
        BYPASS     = byp;
        RESET      = rst;
        in_val[0]  = a0;
        in_val[1]  = a1;
        in_val[2]  = a2;
        if (rst) begin
            m_phase = 0;
            for (int c = 0; c < 3; c++) begin
                m_y[c]    = 0;
                m_filt[c] = 0;
                for (int k = 0; k < 5; k++) m_hist[c][k] = 0;
            end
        end else begin
            do_load = sync || (m_phase == 2);
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int k = 0; k < 5; k++) acc += coef[k] * m_hist[c][k];
                new_y = byp ? m_hist[c][2] : (acc + 8) / 16;
                if (do_load) m_filt[c] = m_y[c];
                m_y[c] = new_y;
                for (int k = 4; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = in_val[c];
            end
            m_phase = do_load ? 0 : m_phase + 1;
        end
        e.en = m_phase;
        e.f0 = m_filt[0];
        e.f1 = m_filt[1];
        e.f2 = m_filt[2];
        sb_queue.push_back(e);
        @(posedge CLK120);
        #1;
        checkOutput();
    endtask

    vec_t impulse_tbl [8];
    int   ramp_exp    [7];
    bit   found;

    initial begin
        checks     = 0;
        errors     = 0;
        coef[0] = 1; coef[1] = 4; coef[2] = 6; coef[3] = 4; coef[4] = 1;
        impulse_tbl[0] = '{1600, 1'b1, 0};
        impulse_tbl[1] = '{0,    1'b1, 0};
        impulse_tbl[2] = '{0,    1'b1, 100};
        impulse_tbl[3] = '{0,    1'b1, 400};
        impulse_tbl[4] = '{0,    1'b1, 600};
        impulse_tbl[5] = '{0,    1'b1, 400};
        impulse_tbl[6] = '{0,    1'b1, 100};
        impulse_tbl[7] = '{0,    1'b1, 0};
        ramp_exp[0] = 0; ramp_exp[1] = 0; ramp_exp[2] = 256; ramp_exp[3] = 1280;
        ramp_exp[4] = 2815; ramp_exp[5] = 3839; ramp_exp[6] = 4095;
        ADC0 = '0; ADC1 = '0; ADC2 = '0;
        PHASE_SYNC = 1'b0; BYPASS = 1'b0; RESET = 1'b1;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check_value("reset_enable40", int'(ENABLE40), 0);
        check_value("reset_filt0", int'(FILT0), 0);

        $display("[TB] constant 1000 on all channels");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1000, 1000, 1000, 0, 0, 0);
            check_value("const_phase", int'(ENABLE40), (i + 1) % 3);
            checks++;
            if (FILT1 > 12'd1000) begin
                errors++;
                $display("[TB] FAIL const_overshoot: got %0d, expected at most 1000", FILT1);
            end
        end
        check_value("const_filt0", int'(FILT0), 1000);
        check_value("const_filt2", int'(FILT2), 1000);

        $display("[TB] step on ADC0 with aligned sync");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1600, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1600, 0, 0, 0, 0, 0);
        check_value("step_filt0", int'(FILT0), 1600);
        check_value("step_filt1", int'(FILT1), 0);

        $display("[TB] impulse on ADC1 with sync held");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, impulse_tbl[i].adc1, 0, impulse_tbl[i].sync, 0, 0);
            check_value("impulse_filt1", int'(FILT1), impulse_tbl[i].exp_f1);
            check_value("impulse_enable40", int'(ENABLE40), 0);
        end

        $display("[TB] bypass ramp on ADC2");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, i, 0, 1, 0);
            if (ENABLE40 == 2'd0 && i >= 4) begin
                check_value("bypass_filt2", int'(FILT2), i - 4);
            end
        end

        $display("[TB] sync pulse at phase 1");
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            if (ENABLE40 == 2'd1) found = 1;
        end
        check_value("sync_find_phase1", int'(found), 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        check_value("sync_enable_0", int'(ENABLE40), 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            check_value("sync_enable_seq", int'(ENABLE40), i % 3);
        end

        $display("[TB] full scale with mid-stream reset");
        for (int i = 0; i < 10; i++) applyStimulus(4095, 4095, 4095, 0, 0, 0);
        check_value("full_filt0", int'(FILT0), 4095);
        check_value("full_filt2", int'(FILT2), 4095);
        applyStimulus(4095, 4095, 4095, 0, 0, 1);
        check_value("midreset_enable40", int'(ENABLE40), 0);
        check_value("midreset_filt1", int'(FILT1), 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4095, 4095, 4095, 1, 0, 0);
            check_value("reramp_filt0", int'(FILT0), ramp_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
